// File: rtl/serializador_pkg.sv
// serializador_pkg: shared constants and types for the byte-to-bit transmitter.
//   BYTE_W      : width of one transmitted byte
//   BIT_CNT_W   : width of the bit index within a byte
//   state_ser_t : transmitter FSM state encoding
package serializador_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_ser_t;

endpackage

// File: rtl/ser_byte_fifo.sv
// ser_byte_fifo: DEPTH-entry byte FIFO with a combinational head read.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   push     : write wdata (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   wdata    : byte to store
//   rdata    : current head entry
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of stored entries, clog2(DEPTH)+1 bits
module ser_byte_fifo
  import serializador_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        wdata,
  output logic [BYTE_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic do_push;
  logic do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Guarding here as well as at the top keeps the FIFO safe on its own.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/serializador.sv
// serializador: queues bytes in a small FIFO and shifts each one out LSB
// first, one bit per transfer, pacing itself on the receiver's readiness.
// Ports:
//   clock_100KHz : single clock, rising edge
//   reset        : synchronous active-high reset
//   data_in      : byte to transmit
//   write_in     : byte valid, accepted when status_out=1
//   status_out   : 1 while the FIFO can take another byte
//   data_out     : current serial bit
//   write_out    : data_out is valid
//   status_in    : receiver can accept a bit
//   empty_out    : nothing queued and nothing in flight
//   state_o      : FSM state, for observation
//
// Handshake: a bit moves on every rising edge where write_out=1 and
// status_in=1; while status_in=0 both data_out and write_out hold. A byte
// moves in on every rising edge where write_in=1 and status_out=1.
module serializador
  import serializador_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock_100KHz,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              write_in,
  output logic              status_out,
  output logic              data_out,
  output logic              write_out,
  input  logic              status_in,
  output logic              empty_out,
  output state_ser_t        state_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_ser_t           state_q;
  logic [BYTE_W-1:0]    shreg_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 write_out_q;

  logic [BYTE_W-1:0]    fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_push_d;
  logic                 fifo_pop_d;
  logic                 last_bit_d;

  assign last_bit_d  = (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));
  assign fifo_push_d = write_in && !fifo_full;

  // Pop on the initial load from IDLE, and on the final transfer of a byte
  // when another one is waiting, so consecutive bytes run with no gap.
  always_comb begin
    fifo_pop_d = 1'b0;
    if (!fifo_empty) begin
      if (state_q == IDLE) begin
        fifo_pop_d = 1'b1;
      end else if (status_in && last_bit_d) begin
        fifo_pop_d = 1'b1;
      end
    end
  end

  ser_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock_100KHz),
    .rst   (reset),
    .push  (fifo_push_d),
    .pop   (fifo_pop_d),
    .wdata (data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      write_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q     <= SHIFT;
            shreg_q     <= fifo_rdata;
            bit_cnt_q   <= '0;
            write_out_q <= 1'b1;
          end
        end
        SHIFT: begin
          // write_out is always 1 here, so status_in alone marks a transfer.
          if (status_in) begin
            if (!last_bit_d) begin
              shreg_q   <= shreg_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (!fifo_empty) begin
              shreg_q   <= fifo_rdata;
              bit_cnt_q <= '0;
            end else begin
              // Clearing the register parks data_out at 0 while idle.
              state_q     <= IDLE;
              shreg_q     <= '0;
              bit_cnt_q   <= '0;
              write_out_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          shreg_q     <= '0;
          bit_cnt_q   <= '0;
          write_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = shreg_q[0];
  assign write_out  = write_out_q;
  assign status_out = (fifo_count != CNT_W'(DEPTH));
  assign empty_out  = (state_q == IDLE) && fifo_empty;
  assign state_o    = state_q;

endmodule
